mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width (matches addrWidth).
REQ-002 SHALL have parameter DATA_W, default 32, data width (matches dataWidth/instWidth).
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have I-port inputs: i_rw_flag  in  2  request, [0] read, 00 none; i_addr  in  ADDR_W  fetch address.
REQ-005 SHALL have I-port outputs: i_read_data  out  DATA_W  fetched word; i_busy  out  1  request pending; i_done  out  1  one-cycle completion pulse.
REQ-006 SHALL have D-port inputs: d_rw_flag  in  2  [0] read, [1] write; d_addr  in  ADDR_W; d_write_data  in  DATA_W; d_write_mask  in  4  byte enables.
REQ-007 SHALL have D-port outputs: d_read_data  out  DATA_W; d_busy  out  1; d_done  out  1.
REQ-008 SHALL have memory outputs: mem_rw_flag  out  2; mem_addr  out  ADDR_W; mem_write_data  out  DATA_W; mem_write_mask  out  4.
REQ-009 SHALL have memory inputs: mem_read_data  in  DATA_W; mem_busy  in  1; mem_done  in  1.

Function
REQ-010 SHALL capture a port request at the rising edge where its rw_flag != 00 and that port has no pending request; captured flag/addr/data/mask held in per-port registers.
REQ-011 SHALL assert x_busy from the edge after capture until the edge that issues x_done; a request presented while x_busy=1 is ignored.
REQ-012 SHALL treat i_rw_flag[1] as absent: I-port requests are always reads; i_rw_flag=10 is ignored, 11 handled as read.
REQ-013 SHALL implement states IDLE, SERVE_I, SERVE_D.
REQ-014 IDLE: when at least one port is pending and mem_busy=0, SHALL grant one port, drive mem_rw_flag = latched flag for exactly one cycle, go to SERVE_x; otherwise stay in IDLE with mem_rw_flag=00.
REQ-015 SHALL arbitrate round-robin: when both are pending, grant the port not served last; last_served resets to D so I wins the first tie.
REQ-016 SHERVE_x: mem_addr/mem_write_data/mem_write_mask SHALL hold the granted port's latched values stable until mem_done; mem_rw_flag SHALL be 00 after the issue cycle.
REQ-017 On mem_done=1 in SERVE_x, at that edge SHALL register x_read_data=mem_read_data (reads only; unchanged for writes), pulse x_done=1 for one cycle, clear x pending/busy, update last_served=x, return to IDLE.
REQ-018 mem_done in IDLE SHALL be ignored.
REQ-019 Latency SHALL be: capture edge k, issue edge k+1 (if IDLE and mem_busy=0), done edge m+1, where m is the cycle mem_done is high; no combinational path from any input to any output.
REQ-020 A request for port x captured on the same edge that the other port's x_done is issued SHALL be eligible for grant on the next edge.
REQ-021 A new request on port x SHALL be accepted in the cycle after x_done.
REQ-022 mem_busy=1 in IDLE SHALL block issue indefinitely; pending requests SHALL be retained.

Reset
REQ-023 rst=0 SHALL immediately force: state IDLE, both pending cleared, last_served=D, all x_busy/x_done=0, x_read_data=0, mem_rw_flag=00, mem_addr/mem_write_data/mem_write_mask=0.
REQ-024 Reset during SERVE_x SHALL abandon the transaction; no x_done SHALL be issued for it, and a late mem_done SHALL be ignored.

Structure
REQ-025 Shared defines file SHALL hold addrWidth, dataWidth, RW_NONE=00, RW_READ=01, RW_WRITE=10, and the arbiter state encodings.
REQ-026 One sub-module, mem_arb_port, SHALL implement per-port request capture, pending/busy, read-data and done registers; instantiated twice.

Verification
REQ-027 I read only: i_rw_flag=01, i_addr=0x100; mem_done 3 cycles after issue with 0xDEADBEEF -> mem_rw_flag=01 one cycle, mem_addr=0x100, i_done one pulse, i_read_data=0xDEADBEEF.
REQ-028 Simultaneous: I read 0x200 and D write 0x300 data 0x12345678 mask 1111 on same edge after reset -> I served first, then D; mem_rw_flag 01 then 10; D write data/mask stable until mem_done.
REQ-029 Round-robin: both ports re-request continuously for 6 transactions -> grants alternate I,D,I,D,I,D; no port waits more than one other transaction.
REQ-030 mem_busy=1 for 10 cycles with D read pending -> no issue; issue on first edge with mem_busy=0; d_busy high throughout.
REQ-031 Reset mid SERVE_D, then mem_done=1 -> no d_done, all outputs at reset values, next I request served normally.
REQ-032 Repeat request while busy: d_rw_flag=01 addr 0x40, then d_rw_flag=10 addr 0x80 while d_busy -> single transaction to 0x40 only.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, request-flag encodings and arbiter state types for the
// two-port (instruction/data) memory arbiter.
package mem_arbiter_pkg;

    localparam int addrWidth = 32;
    localparam int dataWidth = 32;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    function automatic logic is_read(input logic [1:0] flag);
        return (flag & RW_READ) != RW_NONE;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and shared memory bus signals.
// The arbiter uses the slave view; the clients/memory model use the master view.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
    parameter int ADDR_W = addrWidth,
    parameter int DATA_W = dataWidth
);
    logic [1:0]        i_rw_flag;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_read_data;
    logic              i_busy;
    logic              i_done;

    logic [1:0]        d_rw_flag;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_write_data;
    logic [3:0]        d_write_mask;
    logic [DATA_W-1:0] d_read_data;
    logic              d_busy;
    logic              d_done;

    logic [1:0]        mem_rw_flag;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [3:0]        mem_write_mask;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_busy;
    logic              mem_done;

    modport slave (
        input  i_rw_flag, i_addr,
        output i_read_data, i_busy, i_done,
        input  d_rw_flag, d_addr, d_write_data, d_write_mask,
        output d_read_data, d_busy, d_done,
        output mem_rw_flag, mem_addr, mem_write_data, mem_write_mask,
        input  mem_read_data, mem_busy, mem_done
    );

    modport master (
        output i_rw_flag, i_addr,
        input  i_read_data, i_busy, i_done,
        output d_rw_flag, d_addr, d_write_data, d_write_mask,
        input  d_read_data, d_busy, d_done,
        input  mem_rw_flag, mem_addr, mem_write_data, mem_write_mask,
        output mem_read_data, mem_busy, mem_done
    );

endinterface

// File: rtl/mem_arbiter_port.sv
// One client port: captures a request when idle, holds it pending until the
// arbiter reports completion, then registers read data and a one-cycle done.
module mem_arb_port import mem_arbiter_pkg::*; #(
    parameter int ADDR_W = addrWidth,
    parameter int DATA_W = dataWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_flag_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [3:0]        req_mask_i,
    input  logic              done_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              pending_o,
    output logic [1:0]        flag_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [3:0]        mask_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o
);
    logic              pend_q, pend_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        flag_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        mask_q;
    logic              capture;

    assign capture = !pend_q && (req_flag_i != RW_NONE);

    always_comb begin
        pend_d  = pend_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        if (done_i) begin
            pend_d = 1'b0;
            done_d = 1'b1;
            if (is_read(flag_q)) rdata_d = mem_rdata_i;
        end else if (capture) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Payload is only consumed while pending, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            flag_q  <= req_flag_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            mask_q  <= req_mask_i;
        end
    end

    assign pending_o = pend_q;
    assign flag_o    = flag_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign mask_o    = mask_q;
    assign rdata_o   = rdata_q;
    assign done_o    = done_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between an instruction-fetch
// port (read only) and a data port; all outputs are registered.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int ADDR_W = addrWidth,
    parameter int DATA_W = dataWidth
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    logic              i_pend, d_pend, i_evt, d_evt, grant_i;
    logic [1:0]        i_req, i_flag, d_flag;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata;
    logic [3:0]        i_mask, d_mask;

    arb_state_e        state_q;
    port_e             last_q;
    logic [1:0]        mem_rw_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_mask_q;

    // The fetch port has no write capability: its write bit is dropped.
    assign i_req = bus.i_rw_flag & ~RW_WRITE;

    assign i_evt   = (state_q == SERVE_I) && bus.mem_done;
    assign d_evt   = (state_q == SERVE_D) && bus.mem_done;
    assign grant_i = i_pend && (!d_pend || (last_q == PORT_D));

    mem_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_i (
        .clk(clk), .rst(rst),
        .req_flag_i(i_req), .req_addr_i(bus.i_addr),
        .req_wdata_i('0), .req_mask_i('0),
        .done_i(i_evt), .mem_rdata_i(bus.mem_read_data),
        .pending_o(i_pend), .flag_o(i_flag), .addr_o(i_addr),
        .wdata_o(i_wdata), .mask_o(i_mask),
        .rdata_o(bus.i_read_data), .done_o(bus.i_done)
    );

    mem_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_d (
        .clk(clk), .rst(rst),
        .req_flag_i(bus.d_rw_flag), .req_addr_i(bus.d_addr),
        .req_wdata_i(bus.d_write_data), .req_mask_i(bus.d_write_mask),
        .done_i(d_evt), .mem_rdata_i(bus.mem_read_data),
        .pending_o(d_pend), .flag_o(d_flag), .addr_o(d_addr),
        .wdata_o(d_wdata), .mask_o(d_mask),
        .rdata_o(bus.d_read_data), .done_o(bus.d_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= PORT_D;
            mem_rw_q    <= RW_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
        end else begin
            mem_rw_q <= RW_NONE;
            case (state_q)
                IDLE: begin
                    if (!bus.mem_busy && (i_pend || d_pend)) begin
                        if (grant_i) begin
                            mem_rw_q    <= i_flag;
                            mem_addr_q  <= i_addr;
                            mem_wdata_q <= i_wdata;
                            mem_mask_q  <= i_mask;
                            state_q     <= SERVE_I;
                        end else begin
                            mem_rw_q    <= d_flag;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            mem_mask_q  <= d_mask;
                            state_q     <= SERVE_D;
                        end
                    end
                end
                SERVE_I: begin
                    if (bus.mem_done) begin
                        last_q  <= PORT_I;
                        state_q <= IDLE;
                    end
                end
                SERVE_D: begin
                    if (bus.mem_done) begin
                        last_q  <= PORT_D;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.i_busy         = i_pend;
    assign bus.d_busy         = d_pend;
    assign bus.mem_rw_flag    = mem_rw_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_write_mask = mem_mask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable memory
// responder that logs every issued transaction.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();
    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int errors = 0;
    int checks = 0;

    // Memory responder: mem_done rises resp_lat cycles after the issue cycle.
    int          resp_lat;
    logic [31:0] resp_data;
    logic        rsp_done = 1'b0;
    logic        force_done;
    int          cnt = 0;
    int          stab_err = 0;
    logic [1:0]  cap_flag;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_mask;
    logic [1:0]  log_flag[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_mask[$];

    assign ifc.mem_done = rsp_done | force_done;

    always @(posedge clk) begin
        rsp_done <= 1'b0;
        if (!rst) begin
            cnt = 0;
        end else if (ifc.mem_rw_flag != 2'b00) begin
            if (cnt != 0) stab_err++;
            log_flag.push_back(ifc.mem_rw_flag);
            log_addr.push_back(ifc.mem_addr);
            log_wdata.push_back(ifc.mem_write_data);
            log_mask.push_back(ifc.mem_write_mask);
            cap_flag  = ifc.mem_rw_flag;
            cap_addr  = ifc.mem_addr;
            cap_wdata = ifc.mem_write_data;
            cap_mask  = ifc.mem_write_mask;
            cnt = resp_lat - 1;
        end else if (cnt > 0) begin
            if (ifc.mem_addr !== cap_addr || ifc.mem_write_data !== cap_wdata ||
                ifc.mem_write_mask !== cap_mask) stab_err++;
            if (cnt == 1) begin
                rsp_done <= 1'b1;
                ifc.mem_read_data <= resp_data;
            end
            cnt = cnt - 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifc.i_rw_flag    = 2'b00;
        ifc.i_addr       = '0;
        ifc.d_rw_flag    = 2'b00;
        ifc.d_addr       = '0;
        ifc.d_write_data = '0;
        ifc.d_write_mask = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        force_done   = 1'b0;
        ifc.mem_busy = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_i_done(input int max, output int cyc);
        cyc = 0;
        while (ifc.i_done !== 1'b1 && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_d_done(input int max, output int cyc);
        cyc = 0;
        while (ifc.d_done !== 1'b1 && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        force_done   = 1'b0;
        ifc.mem_busy = 1'b0;
        tick();
        checks++;
        if ({ifc.i_busy, ifc.d_busy, ifc.i_done, ifc.d_done, ifc.mem_rw_flag} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {ifc.i_busy, ifc.d_busy, ifc.i_done, ifc.d_done, ifc.mem_rw_flag});
        end
        checks++;
        if (ifc.i_read_data !== 32'h0) begin
            errors++; $display("FAIL reset_i_rdata: got %h expected 0", ifc.i_read_data);
        end
        checks++;
        if (ifc.d_read_data !== 32'h0) begin
            errors++; $display("FAIL reset_d_rdata: got %h expected 0", ifc.d_read_data);
        end
        checks++;
        if (ifc.mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mem_addr: got %h expected 0", ifc.mem_addr);
        end
        checks++;
        if ({ifc.mem_write_data, ifc.mem_write_mask} !== 36'h0) begin
            errors++;
            $display("FAIL reset_mem_wdata: got %h/%h expected 0/0", ifc.mem_write_data, ifc.mem_write_mask);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_i_read();
        int cyc;
        resp_lat  = 3;
        resp_data = 32'hDEADBEEF;
        ifc.i_rw_flag = 2'b01;
        ifc.i_addr    = 32'h100;
        tick();
        checks++;
        if ({ifc.i_busy, ifc.mem_rw_flag} !== 3'b100) begin
            errors++; $display("FAIL iread_capture: busy/flag got %b expected 100", {ifc.i_busy, ifc.mem_rw_flag});
        end
        ifc.i_rw_flag = 2'b00;
        tick();
        checks++;
        if (ifc.mem_rw_flag !== 2'b01 || ifc.mem_addr !== 32'h100) begin
            errors++; $display("FAIL iread_issue: got %b/%h expected 01/00000100", ifc.mem_rw_flag, ifc.mem_addr);
        end
        tick();
        checks++;
        if (ifc.mem_rw_flag !== 2'b00 || ifc.i_busy !== 1'b1) begin
            errors++; $display("FAIL iread_one_cycle: flag/busy got %b/%b expected 00/1", ifc.mem_rw_flag, ifc.i_busy);
        end
        wait_i_done(20, cyc);
        checks++;
        if (ifc.i_done !== 1'b1 || cyc != 3) begin
            errors++; $display("FAIL iread_latency: done=%b after %0d cycles, expected 1 after 3", ifc.i_done, cyc);
        end
        checks++;
        if (ifc.i_read_data !== 32'hDEADBEEF || ifc.i_busy !== 1'b0) begin
            errors++; $display("FAIL iread_data: got %h busy %b expected deadbeef busy 0", ifc.i_read_data, ifc.i_busy);
        end
        tick();
        checks++;
        if (ifc.i_done !== 1'b0) begin
            errors++; $display("FAIL iread_pulse: i_done got %b expected 0", ifc.i_done);
        end
    endtask

    task automatic test_simultaneous();
        int cyc, base, s0;
        do_reset();
        base = log_addr.size();
        s0   = stab_err;
        resp_lat  = 2;
        resp_data = 32'h0BADF00D;
        ifc.i_rw_flag    = 2'b01;
        ifc.i_addr       = 32'h200;
        ifc.d_rw_flag    = 2'b10;
        ifc.d_addr       = 32'h300;
        ifc.d_write_data = 32'h12345678;
        ifc.d_write_mask = 4'hF;
        tick();
        checks++;
        if ({ifc.i_busy, ifc.d_busy} !== 2'b11) begin
            errors++; $display("FAIL simul_capture: busy got %b expected 11", {ifc.i_busy, ifc.d_busy});
        end
        clear_inputs();
        wait_i_done(20, cyc);
        checks++;
        if (ifc.i_done !== 1'b1 || ifc.d_busy !== 1'b1) begin
            errors++; $display("FAIL simul_i_first: i_done/d_busy got %b/%b expected 1/1", ifc.i_done, ifc.d_busy);
        end
        checks++;
        if (ifc.i_read_data !== 32'h0BADF00D) begin
            errors++; $display("FAIL simul_i_rdata: got %h expected 0badf00d", ifc.i_read_data);
        end
        wait_d_done(20, cyc);
        checks++;
        if (ifc.d_done !== 1'b1 || ifc.d_read_data !== 32'h0) begin
            errors++; $display("FAIL simul_d_done: done/rdata got %b/%h expected 1/00000000", ifc.d_done, ifc.d_read_data);
        end
        checks++;
        if (log_addr.size() < base + 2) begin
            errors++; $display("FAIL simul_issues: got %0d expected 2", log_addr.size() - base);
        end else begin
            if (log_flag[base] !== 2'b01 || log_addr[base] !== 32'h200) begin
                errors++; $display("FAIL simul_first: got %b/%h expected 01/00000200", log_flag[base], log_addr[base]);
            end
            checks++;
            if ({log_flag[base+1], log_addr[base+1], log_wdata[base+1], log_mask[base+1]} !==
                {2'b10, 32'h300, 32'h12345678, 4'hF}) begin
                errors++;
                $display("FAIL simul_second: got %b/%h/%h/%h expected 10/00000300/12345678/f",
                         log_flag[base+1], log_addr[base+1], log_wdata[base+1], log_mask[base+1]);
            end
        end
        checks++;
        if (stab_err != s0) begin
            errors++; $display("FAIL simul_stable: bus changes got %0d expected 0", stab_err - s0);
        end
    endtask

    task automatic test_round_robin();
        int n, base, s0;
        logic [31:0] exp_a;
        do_reset();
        base = log_addr.size();
        s0   = stab_err;
        resp_lat  = 2;
        resp_data = 32'h11112222;
        ifc.i_rw_flag = 2'b01;
        ifc.i_addr    = 32'h1000;
        ifc.d_rw_flag = 2'b01;
        ifc.d_addr    = 32'h2000;
        n = 0;
        while (log_addr.size() < base + 6 && n < 200) begin
            tick();
            n++;
        end
        clear_inputs();
        checks++;
        if (log_addr.size() < base + 6) begin
            errors++; $display("FAIL rr_issues: got %0d expected 6", log_addr.size() - base);
        end else begin
            for (int k = 0; k < 6; k++) begin
                exp_a = (k % 2 == 0) ? 32'h1000 : 32'h2000;
                checks++;
                if (log_addr[base+k] !== exp_a) begin
                    errors++; $display("FAIL rr_grant%0d: got %h expected %h", k, log_addr[base+k], exp_a);
                end
            end
        end
        n = 0;
        while ((ifc.i_busy || ifc.d_busy) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (ifc.i_busy !== 1'b0 || ifc.d_busy !== 1'b0 || stab_err != s0) begin
            errors++; $display("FAIL rr_drain: busy %b%b stable_errs %0d expected 00 and 0",
                               ifc.i_busy, ifc.d_busy, stab_err - s0);
        end
        tick();
    endtask

    task automatic test_mem_busy();
        int cyc;
        resp_lat  = 2;
        resp_data = 32'h600DCAFE;
        ifc.mem_busy  = 1'b1;
        ifc.d_rw_flag = 2'b01;
        ifc.d_addr    = 32'h44;
        tick();
        ifc.d_rw_flag = 2'b00;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ifc.mem_rw_flag !== 2'b00 || ifc.d_busy !== 1'b1) begin
                errors++; $display("FAIL busy_hold%0d: flag/d_busy got %b/%b expected 00/1", i, ifc.mem_rw_flag, ifc.d_busy);
            end
            if (i < 9) tick();
        end
        ifc.mem_busy = 1'b0;
        tick();
        checks++;
        if (ifc.mem_rw_flag !== 2'b01 || ifc.mem_addr !== 32'h44) begin
            errors++; $display("FAIL busy_release: got %b/%h expected 01/00000044", ifc.mem_rw_flag, ifc.mem_addr);
        end
        wait_d_done(20, cyc);
        checks++;
        if (ifc.d_done !== 1'b1 || ifc.d_read_data !== 32'h600DCAFE) begin
            errors++; $display("FAIL busy_rdata: done/rdata got %b/%h expected 1/600dcafe", ifc.d_done, ifc.d_read_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_serve();
        int cyc;
        resp_lat  = 8;
        resp_data = 32'h77778888;
        ifc.d_rw_flag = 2'b01;
        ifc.d_addr    = 32'h88;
        tick();
        ifc.d_rw_flag = 2'b00;
        tick();
        checks++;
        if (ifc.mem_rw_flag !== 2'b01) begin
            errors++; $display("FAIL rstmid_issue: got %b expected 01", ifc.mem_rw_flag);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({ifc.d_busy, ifc.mem_rw_flag} !== 3'b000 || ifc.mem_addr !== 32'h0) begin
            errors++; $display("FAIL rstmid_async: busy/flag/addr got %b/%b/%h expected 0/00/0",
                               ifc.d_busy, ifc.mem_rw_flag, ifc.mem_addr);
        end
        checks++;
        if (ifc.d_read_data !== 32'h0 || ifc.i_read_data !== 32'h0) begin
            errors++; $display("FAIL rstmid_rdata: got %h/%h expected 0/0", ifc.d_read_data, ifc.i_read_data);
        end
        tick();
        rst        = 1'b1;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ifc.d_done, ifc.d_busy, ifc.mem_rw_flag} !== 4'b0000) begin
                errors++; $display("FAIL rstmid_late_done%0d: done/busy/flag got %b/%b/%b expected 0/0/00",
                                   i, ifc.d_done, ifc.d_busy, ifc.mem_rw_flag);
            end
            tick();
        end
        resp_lat  = 2;
        resp_data = 32'hCAFEF00D;
        ifc.i_rw_flag = 2'b01;
        ifc.i_addr    = 32'h300;
        tick();
        ifc.i_rw_flag = 2'b00;
        wait_i_done(20, cyc);
        checks++;
        if (ifc.i_done !== 1'b1 || ifc.i_read_data !== 32'hCAFEF00D || log_addr[$] !== 32'h300) begin
            errors++; $display("FAIL rstmid_recover: done/rdata/addr got %b/%h/%h expected 1/cafef00d/00000300",
                               ifc.i_done, ifc.i_read_data, log_addr[$]);
        end
        tick();
    endtask

    task automatic test_i_flag();
        int cyc;
        resp_lat  = 2;
        resp_data = 32'h0000ABCD;
        ifc.i_rw_flag = 2'b10;
        ifc.i_addr    = 32'h500;
        tick();
        tick();
        checks++;
        if (ifc.i_busy !== 1'b0 || ifc.mem_rw_flag !== 2'b00) begin
            errors++; $display("FAIL iflag_10_ignored: busy/flag got %b/%b expected 0/00", ifc.i_busy, ifc.mem_rw_flag);
        end
        ifc.i_rw_flag = 2'b11;
        tick();
        ifc.i_rw_flag = 2'b00;
        tick();
        checks++;
        if (ifc.mem_rw_flag !== 2'b01 || ifc.mem_addr !== 32'h500) begin
            errors++; $display("FAIL iflag_11_read: got %b/%h expected 01/00000500", ifc.mem_rw_flag, ifc.mem_addr);
        end
        wait_i_done(20, cyc);
        checks++;
        if (ifc.i_done !== 1'b1 || ifc.i_read_data !== 32'h0000ABCD) begin
            errors++; $display("FAIL iflag_rdata: done/rdata got %b/%h expected 1/0000abcd", ifc.i_done, ifc.i_read_data);
        end
        tick();
    endtask

    task automatic test_repeat_while_busy();
        int cyc, base;
        base = log_addr.size();
        resp_lat  = 3;
        resp_data = 32'h40404040;
        ifc.d_rw_flag = 2'b01;
        ifc.d_addr    = 32'h40;
        tick();
        checks++;
        if (ifc.d_busy !== 1'b1) begin
            errors++; $display("FAIL repeat_busy: d_busy got %b expected 1", ifc.d_busy);
        end
        ifc.d_rw_flag    = 2'b10;
        ifc.d_addr       = 32'h80;
        ifc.d_write_data = 32'hAA;
        ifc.d_write_mask = 4'h3;
        wait_d_done(20, cyc);
        clear_inputs();
        checks++;
        if (ifc.d_done !== 1'b1 || ifc.d_read_data !== 32'h40404040) begin
            errors++; $display("FAIL repeat_done: done/rdata got %b/%h expected 1/40404040", ifc.d_done, ifc.d_read_data);
        end
        repeat (6) tick();
        checks++;
        if (log_addr.size() != base + 1) begin
            errors++; $display("FAIL repeat_count: issues got %0d expected 1", log_addr.size() - base);
        end else if (log_addr[base] !== 32'h40 || log_flag[base] !== 2'b01) begin
            errors++; $display("FAIL repeat_target: got %b/%h expected 01/00000040", log_flag[base], log_addr[base]);
        end
        checks++;
        if (ifc.d_busy !== 1'b0) begin
            errors++; $display("FAIL repeat_idle: d_busy got %b expected 0", ifc.d_busy);
        end
    endtask

    initial begin
        resp_lat  = 2;
        resp_data = '0;
        test_reset();
        test_i_read();
        test_simultaneous();
        test_round_robin();
        test_mem_busy();
        test_reset_mid_serve();
        test_i_flag();
        test_repeat_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
